// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// Gate-level N-bit ripple-carry adder used by the multiplier datapath.
module n_bit_ripple_carry_adder
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial-product step per clock,
// signed operands handled as magnitudes with the sign applied at the end.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for an operation, in_ready high
// ST_CALC | WIDTH shift-add steps in progress
// ST_DONE | product held on result until out_ready
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mcand_q;
    // Upper half accumulates partial products; the multiplier sits in the
    // lower half and shifts out as product bits shift in.
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     hi_next;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] neg_sum;
    logic               neg_cout_unused;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (is_signed && a[WIDTH-1]) ? ((~a) + WIDTH'(1)) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? ((~b) + WIDTH'(1)) : b;

    n_bit_ripple_carry_adder #(.N(WIDTH)) u_acc_add (
        .a    (acc_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The adder carry forms bit 2*WIDTH of the pre-shift accumulator and
    // lands in the top bit after the right shift.
    assign hi_next  = acc_q[0] ? {add_cout, add_sum} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign acc_step = {hi_next, acc_q[WIDTH-1:1]};

    // Two's-complement negation of the finished product: ~acc + 1.
    n_bit_ripple_carry_adder #(.N(2*WIDTH)) u_neg_add (
        .a    (~acc_step),
        .b    ('0),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_cout_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture at accept and one shift-add step per CALC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            mcand_q <= a_mag;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            neg_q   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= '0;
        end else if (state_q == ST_CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
                result_q <= neg_q ? neg_sum : acc_step;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=8 main, WIDTH=16 extra).
module tb_seq_shift_add_multiplier;

    localparam int W  = 8;
    localparam int W2 = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          is_signed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic          busy;

    logic           iv16 = 1'b0;
    logic           ir16;
    logic [W2-1:0]  a16 = '0;
    logic [W2-1:0]  b16 = '0;
    logic           s16 = 1'b0;
    logic           ov16;
    logic           or16 = 1'b0;
    logic [2*W2-1:0] r16;
    logic           busy16;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    seq_shift_add_multiplier #(.WIDTH(W2)) u_dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .is_signed (s16),
        .out_valid (ov16),
        .out_ready (or16),
        .result    (r16),
        .busy      (busy16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        int             t;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   holding = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random, 3: manual

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref8(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    function automatic logic [2*W2-1:0] ref16(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'(x) * longint'(y);
        return p[2*W2-1:0];
    endfunction

    // Monitor: pops an expectation when a result appears, checks value,
    // latency, stability while held, and handshake levels every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (out_valid && !holding) begin
                    if (sbq.size() == 0) begin
                        check("out_valid_unexpected", out_valid, 0);
                    end else begin
                        cur = sbq.pop_front();
                        holding = 1'b1;
                        check("result", result, cur.res);
                        check("latency", cyc - cur.t, W);
                    end
                end else if (out_valid && holding) begin
                    check("result_hold", result, cur.res);
                end else if (!out_valid && holding) begin
                    holding = 1'b0;
                end
                check("in_ready", in_ready, (sbq.size() == 0 && !holding));
                check("busy", busy, !(sbq.size() == 0 && !holding));
            end
        end
    end

    // out_ready driver.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit keep_valid);
        int n;
        @(negedge clk);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sbq.push_back('{res: ref8(x, y, s), t: cyc});
        if (!keep_valid) begin
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom);
        end else begin
            n = 0;
            while (!out_valid && n < 200) begin
                a = W'($urandom); b = W'($urandom); is_signed = ~is_signed;
                @(negedge clk);
                n++;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || holding || !in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idle_timeout", in_ready, 1);
    endtask

    task automatic run16(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic s, input logic [2*W2-1:0] exp);
        int n;
        int t0;
        @(negedge clk);
        a16 = x; b16 = y; s16 = s; iv16 = 1'b1;
        check("in_ready16", ir16, 1);
        @(posedge clk);
        #1;
        t0 = cyc;
        iv16 = 1'b0;
        a16 = '1; b16 = '1; s16 = ~s;
        n = 0;
        while (!ov16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid16", ov16, 1);
        check("latency16", cyc - t0, W2);
        check("result16", r16, exp);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check("out_valid16_consumed", ov16, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] edge_vals [5];
        int n;
        edge_vals[0] = 8'h00; edge_vals[1] = 8'h80; edge_vals[2] = 8'h7F;
        edge_vals[3] = 8'hFF; edge_vals[4] = 8'h01;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_result16", r16, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        rdy_mode = 1;
        do_op(8'd255, 8'd255, 1'b0, 1'b0);
        do_op(8'h80, 8'h7F, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);
        do_op(8'h00, 8'h80, 1'b1, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        wait_idle();

        // Held result with out_ready low, then a single-cycle consume.
        rdy_mode = 0;
        do_op(8'hC3, 8'h5A, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("held_out_valid", out_valid, 1);
        rdy_mode = 3;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_consume", out_valid, 0);
        rdy_mode = 1;
        do_op(8'd7, 8'd9, 1'b0, 1'b0);
        wait_idle();

        // Inputs wiggle with in_valid high during CALC.
        do_op(8'd13, 8'd11, 1'b0, 1'b1);
        wait_idle();

        // Reset mid-calculation discards the pending operation.
        do_op(8'd77, 8'd99, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        sbq.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        do_op(8'd3, 8'd5, 1'b0, 1'b0);
        wait_idle();

        // Randomised traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            do_op(ra, rb, 1'($urandom), 1'b0);
        end
        rdy_mode = 1;
        wait_idle();

        run16(16'hFFFF, 16'h8000, 1'b1, 32'h0000_8000);
        run16(16'hFFFF, 16'h8000, 1'b0, 32'h7FFF_8000);
        for (int i = 0; i < 4; i++) begin
            logic [W2-1:0] xa, xb;
            logic          xs;
            xa = W2'($urandom);
            xb = W2'($urandom);
            xs = 1'($urandom);
            run16(xa, xb, xs, ref16(xa, xb, xs));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
